// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the terminal UART path: default UART framing,
// the transmit-arbiter state encoding and a small sizing helper.
package uart_tx_arbiter_pkg;

   // Defaults shared with the uart driver.
   localparam int DEFAULT_DBIT = 8;
   localparam int DEFAULT_BAUD = 19200;

   // Arbiter state encoding.
   localparam logic [1:0] STATE_IDLE = 2'd0;
   localparam logic [1:0] STATE_XFER = 2'd1;
   localparam logic [1:0] STATE_GAP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = STATE_IDLE,
      XFER = STATE_XFER,
      GAP  = STATE_GAP
   } state_e;

   // Width of an index into n requesters (never zero).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first set request at or after
// (ptr+1) mod NREQ, wrapping. Also usable for an rx-side dispatcher.
module uart_tx_arbiter_rr_picker
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = ptr_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] onehot_o,
   output logic [PW-1:0]   index_o,
   output logic            any_o
);

   // Scan candidates in rotation order, keeping the first hit.
   always_comb begin
      int j;
      // NOTE: every output gets a default before the search so no path
      // through the loop leaves a value unassigned, which would infer a latch.
      onehot_o = '0;
      index_o  = '0;
      any_o    = 1'b0;
      j        = 0;
      for (int k = 1; k <= NREQ; k++) begin
         j = (int'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[PW'(j)]) begin
            any_o              = 1'b1;
            index_o            = PW'(j);
            onehot_o[PW'(j)]   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit FIFO between NREQ byte-stream requesters.
// Round-robin grant, locked for a whole packet (until a byte flagged last),
// one byte per two cycles so the registered tx_full is always current.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DBIT    = DEFAULT_DBIT,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*DBIT-1:0] data,
   input  logic [NREQ-1:0]      last,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      grant,
   output logic                 abort,
   input  logic                 tx_full,
   output logic [DBIT-1:0]      w_data,
   output logic                 wr_uart,
   output logic                 busy
);

   localparam int PW = ptr_width(NREQ);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e            state_q;
   logic [NREQ-1:0]   grant_q;
   logic [PW-1:0]     gidx_q;
   logic [PW-1:0]     ptr_q;
   logic [CW-1:0]     cnt_q;
   logic [NREQ-1:0]   ack_q;
   logic              wr_q;
   logic [DBIT-1:0]   wdata_q;
   logic              abort_q;
   logic              busy_q;
   logic              last_q;

   logic [NREQ-1:0]   pick_onehot;
   logic [PW-1:0]     pick_index;
   logic              pick_any;
   logic [DBIT-1:0]   req_bytes [NREQ];

   // Unflatten the byte lanes so the owner's byte is a plain array select.
   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      assign req_bytes[i] = data[i*DBIT +: DBIT];
   end

   uart_tx_arbiter_rr_picker #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_picker (
      .req_i    (req),
      .ptr_i    (ptr_q),
      .onehot_o (pick_onehot),
      .index_o  (pick_index),
      .any_o    (pick_any)
   );

   // Arbitration FSM with all outputs registered; pulses default low.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples values from before this edge, as hardware does.
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= PW'(NREQ - 1);
         cnt_q   <= '0;
         ack_q   <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         abort_q <= 1'b0;
         busy_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         ack_q   <= '0;
         wr_q    <= 1'b0;
         abort_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  grant_q <= pick_onehot;
                  gidx_q  <= pick_index;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (req[gidx_q]) begin
                  // Owner is ready; a full FIFO only stalls, never times out.
                  if (!tx_full) begin
                     wr_q    <= 1'b1;
                     wdata_q <= req_bytes[gidx_q];
                     ack_q   <= grant_q;
                     last_q  <= last[gidx_q];
                     cnt_q   <= '0;
                     state_q <= GAP;
                  end
               end else if ((TIMEOUT != 0) && (int'(cnt_q) + 1 >= TIMEOUT)) begin
                  abort_q <= 1'b1;
                  grant_q <= '0;
                  ptr_q   <= gidx_q;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (last_q) begin
                  grant_q <= '0;
                  ptr_q   <= gidx_q;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  state_q <= XFER;
               end
            end
            default: begin
               grant_q <= '0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack     = ack_q;
   assign grant   = grant_q;
   assign abort   = abort_q;
   assign w_data  = wdata_q;
   assign wr_uart = wr_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized phase,
// every cycle compared against a transaction-level owner/spacer model.
module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int DB = 8;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req;
   logic [N*DB-1:0] data;
   logic [N-1:0]    last;
   logic [N-1:0]    ack;
   logic [N-1:0]    grant;
   logic            abort;
   logic            tx_full;
   logic [DB-1:0]   w_data;
   logic            wr_uart;
   logic            busy;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(N), .DBIT(DB), .TIMEOUT(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .data    (data),
      .last    (last),
      .ack     (ack),
      .grant   (grant),
      .abort   (abort),
      .tx_full (tx_full),
      .w_data  (w_data),
      .wr_uart (wr_uart),
      .busy    (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: who owns the FIFO, whether the spacer cycle is due,
   // and how long the owner has been silent.
   int          m_owner;
   int          m_ptr;
   int          m_wait;
   bit          m_spacer;
   bit          m_lastw;
   logic [N-1:0] e_grant, e_ack;
   logic        e_wr, e_abort, e_busy;
   logic [DB-1:0] e_wdata;

   task automatic model_reset();
      m_owner = -1; m_ptr = N - 1; m_wait = 0; m_spacer = 0; m_lastw = 0;
      e_grant = '0; e_ack = '0; e_wr = 0; e_abort = 0; e_busy = 0; e_wdata = '0;
   endtask

   task automatic model_edge();
      e_wr = 0; e_ack = '0; e_abort = 0;
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (m_owner < 0 && req[j]) begin
               m_owner = j;
               m_wait  = 0;
            end
         end
      end else if (m_spacer) begin
         m_spacer = 0;
         if (m_lastw) begin
            m_ptr   = m_owner;
            m_owner = -1;
         end
      end else if (req[m_owner]) begin
         if (!tx_full) begin
            e_wr             = 1;
            e_wdata          = data[m_owner*DB +: DB];
            e_ack[m_owner]   = 1'b1;
            m_lastw          = last[m_owner];
            m_spacer         = 1;
            m_wait           = 0;
         end
      end else begin
         m_wait++;
         if (m_wait == TO) begin
            e_abort = 1;
            m_ptr   = m_owner;
            m_owner = -1;
            m_wait  = 0;
         end
      end
      e_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      e_busy  = (m_owner >= 0);
   endtask

   // Requester behaviour: pend = bytes left in the current packet.
   int          pend [N];
   logic [DB-1:0] cur [N];
   bit          autorep [N];
   bit          drop_after [N];

   task automatic drive(input int i);
      req[i]            = (pend[i] > 0);
      data[i*DB +: DB]  = cur[i];
      last[i]           = (pend[i] == 1);
   endtask

   task automatic start(input int i, input int len, input logic [DB-1:0] b);
      pend[i] = len;
      cur[i]  = b;
      drive(i);
   endtask

   int          cyc = 0;
   bit          prev_wr = 0;
   logic [DB-1:0] wr_log [$];
   int          wr_cyc [$];

   task automatic step();
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
      cyc++;
      check("grant", grant, e_grant);
      check("ack", ack, e_ack);
      check("wr_uart", wr_uart, e_wr);
      check("busy", busy, e_busy);
      check("abort", abort, e_abort);
      if (e_wr) check("w_data", w_data, e_wdata);
      if (prev_wr) check("wr_spacing", wr_uart, 0);
      prev_wr = wr_uart;
      if (wr_uart) begin
         wr_log.push_back(w_data);
         wr_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
         if (e_ack[i]) begin
            pend[i]--;
            cur[i] = cur[i] + 8'd1;
            if (drop_after[i]) begin
               pend[i] = 0;
               drop_after[i] = 0;
            end else if (pend[i] == 0 && autorep[i]) begin
               pend[i] = 1;
            end
            drive(i);
         end
      end
   endtask

   function automatic bit all_done();
      bit d;
      d = (m_owner < 0);
      for (int i = 0; i < N; i++) if (pend[i] != 0) d = 0;
      return d;
   endfunction

   task automatic drain(input string tag, input int budget);
      int n;
      n = 0;
      while (!all_done() && n < budget) begin
         step();
         n++;
      end
      check({"drain_", tag}, all_done(), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int w;
      bit prev_nz;
      logic [N-1:0] gseq [$];

      reset_n = 1'b0; tx_full = 1'b0; req = '0; data = '0; last = '0;
      model_reset();
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; cur[i] = '0; autorep[i] = 0; drop_after[i] = 0;
      end

      // Reset with every requester asking: nothing granted until release.
      for (int i = 0; i < N; i++) start(i, 1, 8'h10 + 8'(i));
      repeat (3) step();
      check("rst_grant", grant, 4'b0000);
      check("rst_wr", wr_uart, 0);
      check("rst_busy", busy, 0);
      reset_n = 1'b1;
      step();
      check("first_grant", grant, 4'b0001);
      drain("reset", 60);

      // Single requester, three-byte packet.
      wr_log.delete(); wr_cyc.delete();
      start(0, 3, 8'h41);
      drain("pkt3", 40);
      check("pkt3_count", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         check("pkt3_b0", wr_log[0], 8'h41);
         check("pkt3_b1", wr_log[1], 8'h42);
         check("pkt3_b2", wr_log[2], 8'h43);
         check("pkt3_gap01", wr_cyc[1] - wr_cyc[0], 2);
         check("pkt3_gap12", wr_cyc[2] - wr_cyc[1], 2);
      end
      check("pkt3_grant_end", grant, 4'b0000);
      check("pkt3_busy_end", busy, 0);

      // Requesters 1 and 3 streaming single-byte packets must alternate.
      autorep[1] = 1; autorep[3] = 1;
      start(1, 1, 8'h20);
      start(3, 1, 8'h30);
      prev_nz = 0;
      repeat (30) begin
         step();
         if (grant != 0 && !prev_nz) gseq.push_back(grant);
         prev_nz = (grant != 0);
      end
      check("alt_sessions", gseq.size() >= 6, 1);
      if (gseq.size() > 0) check("alt_first", gseq[0], 4'b0010);
      for (int i = 1; i < gseq.size() && i < 6; i++)
         check("alt_next", gseq[i], (gseq[i-1] == 4'b0010) ? 4'b1000 : 4'b0010);
      autorep[1] = 0; autorep[3] = 0;
      drain("alt", 40);

      // Backpressure: tx_full high for 20 cycles stalls without timeout.
      start(2, 3, 8'hA0);
      step();
      check("full_grant_start", grant, 4'b0100);
      tx_full = 1'b1;
      w = 0;
      repeat (20) begin
         step();
         if (wr_uart || abort) w++;
      end
      check("full_no_activity", w, 0);
      check("full_grant_held", grant, 4'b0100);
      tx_full = 1'b0;
      step();
      check("full_resume_wr", wr_uart, 1);
      drain("full", 40);

      // Timeout: requester 2 sends 0x55 then goes silent mid-packet.
      start(2, 2, 8'h55);
      drop_after[2] = 1;
      k = 0;
      do begin
         step();
         k++;
      end while (!e_ack[2] && k < 10);
      check("to_first_byte", w_data, 8'h55);
      k = 0;
      do begin
         step();
         k++;
      end while (!abort && k < 20);
      check("to_latency", k, TO + 1);
      check("to_grant", grant, 4'b0000);
      check("to_busy", busy, 0);
      for (int i = 0; i < N; i++) start(i, 1, 8'hC0 + 8'(i));
      step();
      check("to_next_grant", grant, 4'b1000);
      drain("to", 60);

      // Reset during the spacer of a two-byte packet discards the rest.
      start(1, 2, 8'h60);
      k = 0;
      do begin
         step();
         k++;
      end while (!e_ack[1] && k < 10);
      #1;
      reset_n = 1'b0;
      model_reset();
      prev_wr = 0;
      #1;
      check("rstgap_grant", grant, 4'b0000);
      check("rstgap_wr", wr_uart, 0);
      check("rstgap_busy", busy, 0);
      check("rstgap_ack", ack, 4'b0000);
      pend[1] = 0;
      drive(1);
      wr_log.delete();
      repeat (2) step();
      reset_n = 1'b1;
      repeat (10) step();
      check("rstgap_no_second", wr_log.size(), 0);
      start(1, 1, 8'h70);
      drain("rstgap", 20);
      check("rstgap_fresh_count", wr_log.size(), 1);
      if (wr_log.size() == 1) check("rstgap_fresh_byte", wr_log[0], 8'h70);

      // Randomized traffic with backpressure and abandoned packets.
      repeat (500) begin
         tx_full = ($urandom_range(0, 3) == 0);
         for (int i = 0; i < N; i++) begin
            if (pend[i] == 0) begin
               if ($urandom_range(0, 5) == 0)
                  start(i, int'($urandom_range(1, 4)), 8'($urandom));
            end else if ($urandom_range(0, 60) == 0) begin
               pend[i] = 0;
               drive(i);
            end
         end
         step();
      end
      tx_full = 1'b0;
      drain("random", 300);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO between NREQ byte-stream requesters, e.g. switch-entry echo, status reporter and an rx loop-back path.
- Grants one requester at a time on a round-robin basis and locks the grant for a whole packet, ending at a byte flagged last.
- Drives the UART write interface (w_data / wr_uart) and honours tx_full.
- Sits between the requesters and the uart driver inside the top-level terminal design.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBIT, 8, data bits per byte; matches the uart DBIT.
- TIMEOUT, 1023, idle cycles with req low mid-packet before the grant is forcibly released; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester byte valid; held until ack.
- data  in  NREQ*DBIT  flattened bytes; requester i uses bits [i*DBIT +: DBIT].
- last  in  NREQ  marks the final byte of a packet; qualified by req.
- ack  out  NREQ  one-hot, one-cycle pulse: the byte was accepted.
- grant  out  NREQ  one-hot current owner; all zero when idle.
- abort  out  1  one-cycle pulse when a packet is released by timeout.
- tx_full  in  1  from the uart transmit FIFO.
- w_data  out  DBIT  byte to the uart.
- wr_uart  out  1  one-cycle write strobe to the uart.
- busy  out  1  high while a packet is in progress (state != IDLE).

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, ack=0, wr_uart=0, w_data=0, abort=0, busy=0, rr pointer=NREQ-1, timeout counter=0. All outputs are registered.
- States: IDLE, XFER, GAP.
- IDLE:
  - If req != 0, select the first set req[i] searching from (ptr+1) mod NREQ upward with wrap.
  - Set grant=onehot(i) and go to XFER next cycle. Arbitration latency is 1 cycle.
  - Requests arriving in the same cycle are resolved purely by rotation order.
- XFER:
  - If req[g] && !tx_full: next cycle wr_uart=1, w_data=data[g], ack[g]=1; go to GAP. The timeout counter clears.
  - If req[g] && tx_full: wait; no write. The counter does not increment because the requester is ready.
  - If !req[g]: counter++. When counter reaches TIMEOUT (TIMEOUT != 0), pulse abort, set grant=0, ptr=g, and go to IDLE.
- GAP:
  - Mandatory 1-cycle spacer so tx_full reflects the previous write, since the FIFO full flag is registered. Maximum throughput is 1 byte per 2 cycles.
  - If the accepted byte had last=1: grant=0, ptr=g, go to IDLE. Otherwise return to XFER.
- Requester rules:
  - data and last must be stable while req is high and ack is not yet seen.
  - The requester may present the next byte in the cycle after ack.
  - req from a non-granted requester is held off with no ack; there is no loss.
- Boundaries:
  - tx_full held high stalls indefinitely with no timeout; backpressure is legal.
  - A single-byte packet (last=1 on the first byte) releases after GAP.
  - ptr wraps NREQ-1→0.
  - wr_uart never asserts in consecutive cycles.
  - Reset mid-packet discards the packet. The FIFO keeps any bytes already written.

Decomposition:
- Shared package holds the state encoding localparams (IDLE=2'd0, XFER=2'd1, GAP=2'd2) and the default BAUD/DBIT constants already shared with the uart.
- One natural sub-module, rr_picker: combinational round-robin priority selector.
  - Inputs: req, ptr.
  - Outputs: onehot, index, any.
  - Reusable for a future rx-side dispatcher.

Test Plan:
- Reset: hold reset_n=0 with req=4'b1111 → grant=0, wr_uart=0, busy=0; after release, first grant=4'b0001 (ptr=3 wraps to 0).
- Single requester, 3-byte packet 0x41,0x42,0x43 (last on 0x43), tx_full=0 → three wr_uart pulses exactly 2 cycles apart, w_data in order, ack[0] coincident with each pulse, then grant=0, busy=0.
- req=4'b1010, each sending 1-byte packets, held continuously → grants alternate 0010, 1000, 0010…; requester 1 is never interleaved mid-packet.
- tx_full forced high for 20 cycles during XFER → no wr_uart, no abort, grant held; writes resume 1 cycle after tx_full falls.
- TIMEOUT=8, requester 2 sends byte 0x55 (last=0) and then drops req → abort pulses after 8 idle cycles, grant=0, next arbitration starts searching at index 3.
- Assert reset_n=0 in the GAP of a 2-byte packet → outputs clear immediately; after release no second byte is written until a fresh req.
